// File: rtl/mx_sched_pkg.sv
// Shared codes, FSM state type and op transition table for the mx op scheduler.
package mx_sched_pkg;

  localparam logic [2:0] ST_CAL    = 3'b010;
  localparam logic [2:0] ST_REPCLK = 3'b011;
  localparam logic [2:0] ST_REPVLD = 3'b100;
  localparam logic [2:0] ST_REVMB  = 3'b101;
  localparam logic [2:0] ST_REPMB  = 3'b110;

  localparam logic [2:0] OP_INIT   = 3'b000;
  localparam logic [2:0] OP_RUN    = 3'b001;
  localparam logic [2:0] OP_RESULT = 3'b010;
  localparam logic [2:0] OP_CLRERR = 3'b100;
  localparam logic [2:0] OP_APPLY  = 3'b101;
  localparam logic [2:0] OP_RERUN  = 3'b110;
  // Internal end-of-sequence marker, never driven onto mx_op.
  localparam logic [2:0] OP_DONE   = 3'b111;

  localparam logic [1:0] RESP_OK      = 2'b00;
  localparam logic [1:0] RESP_FAIL    = 2'b01;
  localparam logic [1:0] RESP_TIMEOUT = 2'b10;
  localparam logic [1:0] RESP_ABORT   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } sched_state_e;

  function automatic logic state_ok(input logic [2:0] st);
    return (st >= ST_CAL) && (st <= ST_REPMB);
  endfunction

  function automatic logic [2:0] next_op(
    input logic [2:0] op,
    input logic [2:0] st,
    input logic       success
  );
    logic [2:0] n;
    n = OP_DONE;
    case (op)
      OP_INIT: begin
        if (st == ST_CAL)        n = OP_DONE;
        else if (st == ST_REVMB) n = OP_CLRERR;
        else                     n = OP_RUN;
      end
      OP_RUN:    n = (st == ST_REPMB) ? OP_APPLY : OP_RESULT;
      OP_RESULT: n = (st == ST_REVMB && !success) ? OP_CLRERR : OP_DONE;
      OP_CLRERR: n = OP_RUN;
      OP_APPLY:  n = success ? OP_DONE : OP_RERUN;
      OP_RERUN:  n = OP_DONE;
      default:   n = OP_DONE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mx_op_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mx_op_scheduler.sv
// Round-robin sharing of the mx op engine among link-state requesters.
// Optional MX_SCHED_STATS_EN adds saturating grant/timeout counters.
module mx_op_scheduler
  import mx_sched_pkg::*;
#(
  parameter int NUM_REQ        = 5,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRY      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [3*NUM_REQ-1:0] req_state,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [1:0]           resp_code,
  input  logic                 abort,
  output logic                 mx_start,
  output logic [2:0]           mx_op,
  output logic [2:0]           mx_state,
  input  logic                 mx_done,
  input  logic                 mx_success,
  output logic                 busy
`ifdef MX_SCHED_STATS_EN
  ,
  output logic [31:0]          stat_grants,
  output logic [15:0]          stat_timeouts
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_e state, state_n;

  logic [IW-1:0]      ptr, ptr_n;
  logic [NUM_REQ-1:0] gnt_oh, gnt_oh_n;
  logic [2:0]         gst, gst_n;
  logic [2:0]         op, op_n;
  logic [RW-1:0]      retry, retry_n;
  logic [TW-1:0]      tcnt, tcnt_n, tcnt_inc;
  logic [1:0]         code, code_n;
  logic [2:0]         nop;
  logic               grant_fire;
  logic               to_fire;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= '0;
      gnt_oh <= '0;
      gst    <= '0;
      op     <= OP_INIT;
      retry  <= '0;
      tcnt   <= '0;
      code   <= RESP_OK;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      gnt_oh <= gnt_oh_n;
      gst    <= gst_n;
      op     <= op_n;
      retry  <= retry_n;
      tcnt   <= tcnt_n;
      code   <= code_n;
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    gnt_oh_n   = gnt_oh;
    gst_n      = gst;
    op_n       = op;
    retry_n    = retry;
    tcnt_n     = tcnt;
    code_n     = code;
    req_ready  = '0;
    grant_fire = 1'b0;
    to_fire    = 1'b0;
    tcnt_inc   = tcnt + TW'(1);
    nop        = next_op(op, gst, mx_success);
    unique case (state)
      S_IDLE: begin
        if (arb_any && !rst) begin
          req_ready  = arb_grant;
          grant_fire = 1'b1;
          gnt_oh_n   = arb_grant;
          gst_n      = req_state[3*int'(arb_idx) +: 3];
          op_n       = OP_INIT;
          retry_n    = '0;
          ptr_n      = (int'(arb_idx) == NUM_REQ - 1) ?
                       '0 : arb_idx + IW'(1);
          if (state_ok(req_state[3*int'(arb_idx) +: 3])) begin
            state_n = S_ISSUE;
          end else begin
            code_n  = RESP_FAIL;
            state_n = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        tcnt_n = '0;
        if (abort) begin
          code_n  = RESP_ABORT;
          state_n = S_RESP;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        tcnt_n = tcnt_inc;
        if (abort) begin
          code_n  = RESP_ABORT;
          state_n = S_RESP;
        end else if (mx_done) begin
          unique case (1'b1)
            (nop == OP_DONE): begin
              code_n  = mx_success ? RESP_OK : RESP_FAIL;
              state_n = S_RESP;
            end
            (nop == OP_CLRERR && retry == RW'(MAX_RETRY)): begin
              code_n  = RESP_FAIL;
              state_n = S_RESP;
            end
            default: begin
              if (nop == OP_CLRERR) retry_n = retry + RW'(1);
              op_n    = nop;
              state_n = S_ISSUE;
            end
          endcase
        // The response cycle closes the TIMEOUT_CYCLES window after mx_start.
        end else if (tcnt_inc >= TW'(TIMEOUT_CYCLES - 1)) begin
          code_n  = RESP_TIMEOUT;
          to_fire = 1'b1;
          state_n = S_RESP;
        end
      end
      S_RESP: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign mx_start   = (state == S_ISSUE);
  assign mx_op      = op;
  assign mx_state   = gst;
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_RESP) ? gnt_oh : '0;
  assign resp_code  = (state == S_RESP) ? code : RESP_OK;

`ifdef MX_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (grant_fire && stat_grants != '1)
        stat_grants <= stat_grants + 32'd1;
      if (to_fire && stat_timeouts != '1)
        stat_timeouts <= stat_timeouts + 16'd1;
    end
  end
`endif

endmodule
